// File: rtl/mul_tree_feeder_bf16.sv
// Producer side of the bf16 multiply-tree input: packs a serial operand stream into the
// 128-bit operand bus, strobes once per packet and holds mode stable until the tree drains.
module mul_tree_feeder_bf16 #(
  parameter int unsigned DRAIN_CYCLES = 12,
  parameter logic [15:0] ONE_BF16     = 16'h3F80
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   cfg_mode,
  input  logic [15:0]  s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [127:0] mul_ins,
  output logic         mul_stb,
  output logic [1:0]   mode,
  output logic         busy
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

  logic [1:0]        mode_q, mode_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [127:0]      stage_q, stage_d;
  logic [7:0]        wr_q, wr_d;
  logic [127:0]      ins_q, ins_d;
  logic              stb_q, stb_d;

  logic              xfer;
  logic              complete;
  logic [2:0]        last_idx;
  logic [2:0]        slot;
  logic [127:0]      stage_new;
  logic [7:0]        wr_new;

  assign s_ready = !(cnt_q == 3'd0 && cfg_mode != mode_q);
  assign mul_ins = ins_q;
  assign mul_stb = stb_q;
  assign mode    = mode_q;
  assign busy    = (cnt_q != 3'd0) || (drain_q != '0);

  always_comb begin
    xfer     = s_valid && s_ready;
    last_idx = (mode_q == 2'd1) ? 3'd5 : 3'd7;
    // three_in skips slot 3 so each lane-pair group keeps its identity pad
    slot      = (mode_q == 2'd1 && cnt_q >= 3'd3) ? cnt_q + 3'd1 : cnt_q;
    stage_new = stage_q;
    stage_new[{slot, 4'b0000} +: 16] = s_data;
    wr_new    = wr_q | (8'b1 << slot);
    complete  = xfer && (cnt_q == last_idx || s_last);

    mode_d  = mode_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    stage_d = stage_q;
    wr_d    = wr_q;
    ins_d   = ins_q;
    stb_d   = 1'b0;

    if (xfer) begin
      stage_d = stage_new;
      cnt_d   = complete ? 3'd0 : cnt_q + 3'd1;
      wr_d    = complete ? 8'd0 : wr_new;
    end

    if (complete) begin
      stb_d = 1'b1;
      for (int k = 0; k < 8; k++) begin
        ins_d[k*16 +: 16] = wr_new[k] ? stage_new[k*16 +: 16] : ONE_BF16;
      end
    end

    if (stb_q) begin
      drain_d = DrainW'(DRAIN_CYCLES);
    end else if (drain_q != '0) begin
      drain_d = drain_q - 1'b1;
    end

    // Mode may only move at a packet boundary once every in-flight result has left the tree
    if (cnt_q == 3'd0 && cfg_mode != mode_q && drain_q == '0 && !stb_q) begin
      mode_d = cfg_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q  <= 2'd0;
      cnt_q   <= 3'd0;
      drain_q <= '0;
      stage_q <= '0;
      wr_q    <= 8'd0;
      ins_q   <= '0;
      stb_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      stage_q <= stage_d;
      wr_q    <= wr_d;
      ins_q   <= ins_d;
      stb_q   <= stb_d;
    end
  end

endmodule

// File: tb/tb_mul_tree_feeder_bf16.sv
// Directed bench for mul_tree_feeder_bf16: packing per mode, strobe timing, mode-change
// stall against the drain window, and reset discarding a partial packet.
module tb_mul_tree_feeder_bf16;

  logic         clk;
  logic         rst;
  logic [1:0]   cfg_mode;
  logic [15:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [127:0] mul_ins;
  logic         mul_stb;
  logic [1:0]   mode;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  int stb_cnt = 0;
  int cyc = 0;

  mul_tree_feeder_bf16 #(
    .DRAIN_CYCLES(12),
    .ONE_BF16    (16'h3F80)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_mode(cfg_mode),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .mul_ins (mul_ins),
    .mul_stb (mul_stb),
    .mode    (mode),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mul_stb) stb_cnt <= stb_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one operand, wait (bounded) for s_ready, transfer it; returns #1 after the edge.
  task automatic send(input logic [15:0] d, input logic l, output int stalls);
    s_data  = d;
    s_valid = 1'b1;
    s_last  = l;
    #0;
    stalls  = 0;
    while (!s_ready && stalls < 100) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    if (stalls >= 100) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout: observed stalls %0d expected <100", stalls);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    int st;
    int tot;
    int n;
    int t0;
    int t1;
    int s0;
    logic [1:0] mode13;
    logic [127:0] exp5 [3];

    rst = 1'b0; cfg_mode = 2'd0; s_data = 16'h0; s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mul_ins", mul_ins, 128'h0);
    chk("rst_stb", mul_stb, 1'b0);
    chk("rst_mode", mode, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", s_ready, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: mode 0, eight back-to-back operands
    tot = 0;
    send(16'h3F80, 1'b0, st); tot += st;
    send(16'h4000, 1'b0, st); tot += st;
    send(16'h4040, 1'b0, st); tot += st;
    send(16'h4080, 1'b0, st); tot += st;
    chk("t1_busy_partial", busy, 1'b1);
    chk("t1_no_early_stb", mul_stb, 1'b0);
    chk("t1_ins_held", mul_ins, 128'h0);
    send(16'h40A0, 1'b0, st); tot += st;
    send(16'h40C0, 1'b0, st); tot += st;
    send(16'h40E0, 1'b0, st); tot += st;
    s0 = stb_cnt;
    send(16'h4100, 1'b0, st); tot += st;
    chk("t1_stb", mul_stb, 1'b1);
    chk("t1_ins", mul_ins, 128'h4100_40E0_40C0_40A0_4080_4040_4000_3F80);
    chk("t1_no_stall", tot, 0);
    @(posedge clk);
    #1;
    chk("t1_stb_one_cycle", mul_stb, 1'b0);
    chk("t1_stb_count", stb_cnt - s0, 1);

    // 2: mode 1, six operands
    cfg_mode = 2'd1;
    for (int i = 0; i < 6; i++) send(16'h4000, 1'b0, st);
    chk("t2_stb", mul_stb, 1'b1);
    chk("t2_ins", mul_ins, 128'h3F80_4000_4000_4000_3F80_4000_4000_4000);
    chk("t2_mode", mode, 2'd1);

    // 3: mode 2, s_last on the third operand
    cfg_mode = 2'd2;
    send(16'h4040, 1'b0, st);
    send(16'h4040, 1'b0, st);
    send(16'h4040, 1'b1, st);
    chk("t3_stb", mul_stb, 1'b1);
    chk("t3_ins", mul_ins, 128'h3F80_3F80_3F80_3F80_3F80_4040_4040_4040);
    chk("t3_cnt_zero", busy, 1'b0);
    @(posedge clk);
    #1;
    chk("t3_busy_drain", busy, 1'b1);

    // 4: mode 0 packet, then request mode 3 during the drain window
    cfg_mode = 2'd0;
    for (int i = 0; i < 8; i++) send(16'h1000 + 16'(i), 1'b0, st);
    chk("t4_stb", mul_stb, 1'b1);
    chk("t4_ins", mul_ins, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    s0 = stb_cnt;
    cfg_mode = 2'd3;
    s_data = 16'h3000;
    s_valid = 1'b1;
    #0;
    n = 0;
    mode13 = 2'bxx;
    while (!s_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 13) mode13 = mode;
    end
    chk("t4_stall_len", n, 14);
    chk("t4_mode_held", mode13, 2'd0);
    chk("t4_mode_new", mode, 2'd3);
    chk("t4_stall_stb", stb_cnt - s0, 1);
    for (int i = 0; i < 8; i++) send(16'h3000 + 16'(i), 1'b0, st);
    chk("t4_m3_stb", mul_stb, 1'b1);
    chk("t4_m3_ins", mul_ins, 128'h3007_3006_3005_3004_3003_3002_3001_3000);

    // 5: three continuous mode-0 packets
    exp5[0] = 128'h2007_2006_2005_2004_2003_2002_2001_2000;
    exp5[1] = 128'h2017_2016_2015_2014_2013_2012_2011_2010;
    exp5[2] = 128'h2027_2026_2025_2024_2023_2022_2021_2020;
    cfg_mode = 2'd0;
    t0 = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) send(16'h2000 + 16'(16 * p + i), 1'b0, st);
      t1 = cyc;
      chk($sformatf("t5_stb%0d", p), mul_stb, 1'b1);
      chk($sformatf("t5_ins%0d", p), mul_ins, exp5[p]);
      if (p > 0) chk($sformatf("t5_gap%0d", p), t1 - t0, 8);
      t0 = t1;
    end
    chk("t5_mode", mode, 2'd0);

    // 6: reset in the middle of a mode-2 packet
    cfg_mode = 2'd2;
    for (int i = 0; i < 5; i++) send(16'hAAAA, 1'b0, st);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_rst_ins", mul_ins, 128'h0);
    chk("t6_rst_stb", mul_stb, 1'b0);
    chk("t6_rst_mode", mode, 2'd0);
    chk("t6_rst_busy", busy, 1'b0);
    rst = 1'b1;
    s0 = stb_cnt;
    for (int i = 0; i < 8; i++) send(16'h5000 + 16'(i), 1'b0, st);
    chk("t6_stb", mul_stb, 1'b1);
    chk("t6_ins", mul_ins, 128'h5007_5006_5005_5004_5003_5002_5001_5000);
    chk("t6_mode", mode, 2'd2);
    @(posedge clk);
    #1;
    chk("t6_stb_count", stb_cnt - s0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed time limit reached expected finish");
    $fatal(1, "watchdog");
  end

endmodule
